axi4_lite_booth_regbank: RTL and testbench

AXI4_LITE_BOOTH_REGBANK -- requirements
Module: axi4_lite_booth_regbank

---
 rtl/axi4_lite_booth_regbank_if.sv | 38 +++
 rtl/axi4_lite_booth_regbank.sv | 262 ++++++++++++++++++++++++++
 tb/tb_axi4_lite_booth_regbank.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_booth_regbank_if.sv
// AXI4-Lite bus bundle for the Booth multiplier register bank.
// The master modport drives requests and the slave modport drives responses.
interface axi4_lite_booth_regbank_if #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 8
);
    logic [AXI_ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]                  awprot;
    logic                        awvalid;
    logic                        awready;
    logic [AXI_DATA_WIDTH-1:0]   wdata;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                        wvalid;
    logic                        wready;
    logic [1:0]                  bresp;
    logic                        bvalid;
    logic                        bready;
    logic [AXI_ADDR_WIDTH-1:0]   araddr;
    logic [2:0]                  arprot;
    logic                        arvalid;
    logic                        arready;
    logic [AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                  rresp;
    logic                        rvalid;
    logic                        rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4_lite_booth_regbank.sv
// AXI4-Lite register bank fronting a Booth multiplier: operands, start, status, results.
// Define AXI_LITE_SLVERR_EN to answer illegal accesses with SLVERR instead of OKAY.
module axi4_lite_booth_regbank #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 8,
    parameter int NUM_OPERANDS   = 2,
    parameter int NUM_RESULTS    = 2
) (
    input  logic                                   s_axi_clock,
    input  logic                                   s_axi_reset,
    axi4_lite_booth_regbank_if.slave               s_axi,
    output logic [NUM_OPERANDS*AXI_DATA_WIDTH-1:0] operand_data,
    output logic [NUM_OPERANDS-1:0]                operand_wr_en,
    output logic                                   start_pulse,
    input  logic [NUM_RESULTS*AXI_DATA_WIDTH-1:0]  result_data,
    input  logic                                   result_valid,
    input  logic                                   core_busy
);
    localparam int W     = AXI_DATA_WIDTH;
    localparam int NB    = AXI_DATA_WIDTH / 8;
    localparam int IDX_W = AXI_ADDR_WIDTH - 2;

    localparam logic [IDX_W-1:0] IDX_CTRL   = '0;
    localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(1);
    localparam logic [1:0]       RESP_OKAY  = 2'b00;
`ifdef AXI_LITE_SLVERR_EN
    localparam logic [1:0]       RESP_SLVERR = 2'b10;
`endif

    typedef enum logic [1:0] {W_IDLE, W_ADDR_OK, W_DATA_OK, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t         w_state_q, w_state_d;
    r_state_t         r_state_q, r_state_d;
    logic             awready_q, awready_d;
    logic             wready_q, wready_d;
    logic             bvalid_q, bvalid_d;
    logic [1:0]       bresp_q, bresp_d;
    logic [IDX_W-1:0] aw_idx_q, aw_idx_d;
    logic [W-1:0]     wdata_q, wdata_d;
    logic [NB-1:0]    wstrb_q, wstrb_d;
    logic             arready_q, arready_d;
    logic             rvalid_q, rvalid_d;
    logic [1:0]       rresp_q, rresp_d;
    logic [W-1:0]     rdata_q, rdata_d;
    logic             rd_status_q, rd_status_d;
    logic             done_q, done_d;
    logic [W-1:0]     operand_q [NUM_OPERANDS];
    logic [W-1:0]     operand_d [NUM_OPERANDS];
    logic [W-1:0]     result_q [NUM_RESULTS];
    logic [W-1:0]     result_d [NUM_RESULTS];
    logic [NUM_OPERANDS-1:0] operand_wr_en_q, operand_wr_en_d;
    logic             start_pulse_q, start_pulse_d;

    logic             aw_hs, w_hs, ar_hs, do_write;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic [W-1:0]     wr_data;
    logic [NB-1:0]    wr_strb;

    function automatic logic [W-1:0] apply_strb(input logic [W-1:0] old_v,
                                                 input logic [W-1:0] new_v,
                                                 input logic [NB-1:0] strb);
        logic [W-1:0] r;
        r = old_v;
        for (int b = 0; b < NB; b++) begin
            if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return r;
    endfunction

`ifdef AXI_LITE_SLVERR_EN
    function automatic logic is_operand(input logic [IDX_W-1:0] idx);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_OPERANDS; i++) begin
            if (idx == IDX_W'(2 + i)) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic is_result(input logic [IDX_W-1:0] idx);
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < NUM_RESULTS; j++) begin
            if (idx == IDX_W'(6 + j)) hit = 1'b1;
        end
        return hit;
    endfunction
`endif

    assign aw_hs  = s_axi.awvalid & awready_q;
    assign w_hs   = s_axi.wvalid & wready_q;
    assign ar_hs  = s_axi.arvalid & arready_q;
    assign rd_idx = s_axi.araddr[AXI_ADDR_WIDTH-1:2];

    // Address/data come straight off the bus when that channel completes this cycle.
    assign wr_idx  = aw_hs ? s_axi.awaddr[AXI_ADDR_WIDTH-1:2] : aw_idx_q;
    assign wr_data = w_hs ? s_axi.wdata : wdata_q;
    assign wr_strb = w_hs ? s_axi.wstrb : wstrb_q;

    logic unused_bits;
    assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

    always_comb begin
        w_state_d       = w_state_q;
        aw_idx_d        = aw_idx_q;
        wdata_d         = wdata_q;
        wstrb_d         = wstrb_q;
        bvalid_d        = bvalid_q;
        bresp_d         = bresp_q;
        operand_d       = operand_q;
        operand_wr_en_d = '0;
        start_pulse_d   = 1'b0;
        do_write        = 1'b0;

        case (w_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) do_write = 1'b1;
                else if (aw_hs)    w_state_d = W_ADDR_OK;
                else if (w_hs)     w_state_d = W_DATA_OK;
            end
            W_ADDR_OK: if (w_hs)  do_write = 1'b1;
            W_DATA_OK: if (aw_hs) do_write = 1'b1;
            W_RESP: begin
                if (s_axi.bready) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase

        if (aw_hs) aw_idx_d = s_axi.awaddr[AXI_ADDR_WIDTH-1:2];
        if (w_hs) begin
            wdata_d = s_axi.wdata;
            wstrb_d = s_axi.wstrb;
        end

        if (do_write) begin
            w_state_d = W_RESP;
            bvalid_d  = 1'b1;
            bresp_d   = RESP_OKAY;
`ifdef AXI_LITE_SLVERR_EN
            if (!((wr_idx == IDX_CTRL) || is_operand(wr_idx))) bresp_d = RESP_SLVERR;
`endif
            if (wr_idx == IDX_CTRL) start_pulse_d = wr_strb[0] & wr_data[0];
            for (int i = 0; i < NUM_OPERANDS; i++) begin
                if (wr_idx == IDX_W'(2 + i)) begin
                    operand_d[i]       = apply_strb(operand_q[i], wr_data, wr_strb);
                    operand_wr_en_d[i] = 1'b1;
                end
            end
        end

        awready_d = (w_state_d == W_IDLE) || (w_state_d == W_DATA_OK);
        wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_ADDR_OK);
    end

    always_comb begin
        r_state_d   = r_state_q;
        rvalid_d    = rvalid_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        rd_status_d = rd_status_q;
        done_d      = done_q;
        result_d    = result_q;

        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_d   = R_DATA;
                    rvalid_d    = 1'b1;
                    rd_status_d = (rd_idx == IDX_STATUS);
                    rdata_d     = '0;
                    rresp_d     = RESP_OKAY;
                    if (rd_idx == IDX_STATUS) rdata_d = {{(W-2){1'b0}}, done_q, core_busy};
                    for (int j = 0; j < NUM_RESULTS; j++) begin
                        if (rd_idx == IDX_W'(6 + j)) rdata_d = result_q[j];
                    end
`ifdef AXI_LITE_SLVERR_EN
                    if (!((rd_idx == IDX_STATUS) || is_result(rd_idx))) rresp_d = RESP_SLVERR;
`endif
                end
            end
            R_DATA: begin
                if (s_axi.rready) begin
                    r_state_d = R_IDLE;
                    rvalid_d  = 1'b0;
                    if (rd_status_q) done_d = 1'b0;
                end
            end
            default: r_state_d = R_IDLE;
        endcase

        // A capture in the same cycle as the clearing read must leave done set.
        if (result_valid) begin
            done_d = 1'b1;
            for (int j = 0; j < NUM_RESULTS; j++) result_d[j] = result_data[j*W +: W];
        end

        arready_d = (r_state_d == R_IDLE);
    end

    always_ff @(posedge s_axi_clock or negedge s_axi_reset) begin
        if (!s_axi_reset) begin
            w_state_q       <= W_IDLE;
            r_state_q       <= R_IDLE;
            awready_q       <= 1'b0;
            wready_q        <= 1'b0;
            bvalid_q        <= 1'b0;
            bresp_q         <= RESP_OKAY;
            aw_idx_q        <= '0;
            wdata_q         <= '0;
            wstrb_q         <= '0;
            arready_q       <= 1'b0;
            rvalid_q        <= 1'b0;
            rresp_q         <= RESP_OKAY;
            rdata_q         <= '0;
            rd_status_q     <= 1'b0;
            done_q          <= 1'b0;
            operand_wr_en_q <= '0;
            start_pulse_q   <= 1'b0;
            for (int i = 0; i < NUM_OPERANDS; i++) operand_q[i] <= '0;
            for (int j = 0; j < NUM_RESULTS; j++)  result_q[j]  <= '0;
        end else begin
            w_state_q       <= w_state_d;
            r_state_q       <= r_state_d;
            awready_q       <= awready_d;
            wready_q        <= wready_d;
            bvalid_q        <= bvalid_d;
            bresp_q         <= bresp_d;
            aw_idx_q        <= aw_idx_d;
            wdata_q         <= wdata_d;
            wstrb_q         <= wstrb_d;
            arready_q       <= arready_d;
            rvalid_q        <= rvalid_d;
            rresp_q         <= rresp_d;
            rdata_q         <= rdata_d;
            rd_status_q     <= rd_status_d;
            done_q          <= done_d;
            operand_wr_en_q <= operand_wr_en_d;
            start_pulse_q   <= start_pulse_d;
            operand_q       <= operand_d;
            result_q        <= result_d;
        end
    end

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rdata   = rdata_q;
    assign operand_wr_en = operand_wr_en_q;
    assign start_pulse   = start_pulse_q;

    for (genvar i = 0; i < NUM_OPERANDS; i++) begin : g_operand
        assign operand_data[i*W +: W] = operand_q[i];
    end
endmodule

// File: tb/tb_axi4_lite_booth_regbank.sv
// Directed bench for axi4_lite_booth_regbank: handshakes, strobes, sticky status, reset.
`timescale 1ns/1ps
module tb_axi4_lite_booth_regbank;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NO = 2;
    localparam int NR = 2;
`ifdef AXI_LITE_SLVERR_EN
    localparam logic [1:0] ERR_RESP = 2'b10;
`else
    localparam logic [1:0] ERR_RESP = 2'b00;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NO*DW-1:0] operand_data;
    logic [NO-1:0]    operand_wr_en;
    logic             start_pulse;
    logic [NR*DW-1:0] result_data;
    logic             result_valid;
    logic             core_busy;
    int n_cmp = 0;
    int n_fail = 0;
    int wr_pulse_cnt = 0;
    int start_cnt = 0;

    axi4_lite_booth_regbank_if #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) bus ();

    axi4_lite_booth_regbank #(
        .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .NUM_OPERANDS(NO), .NUM_RESULTS(NR)
    ) dut (
        .s_axi_clock(clk), .s_axi_reset(rst_n), .s_axi(bus),
        .operand_data(operand_data), .operand_wr_en(operand_wr_en), .start_pulse(start_pulse),
        .result_data(result_data), .result_valid(result_valid), .core_busy(core_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (|operand_wr_en) wr_pulse_cnt++;
        if (start_pulse) start_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic aw_send(input logic [AW-1:0] addr);
        int c; logic hs;
        c = 0; hs = 1'b0;
        bus.awaddr = addr; bus.awvalid = 1'b1;
        while (!hs && c < 50) begin
            @(negedge clk); hs = bus.awready;
            @(posedge clk); #1; c++;
        end
        bus.awvalid = 1'b0;
        if (!hs) begin n_cmp++; n_fail++; $display("FAIL aw_timeout: awready=0 required 1"); end
    endtask

    task automatic w_send(input logic [DW-1:0] data, input logic [3:0] strb);
        int c; logic hs;
        c = 0; hs = 1'b0;
        bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
        while (!hs && c < 50) begin
            @(negedge clk); hs = bus.wready;
            @(posedge clk); #1; c++;
        end
        bus.wvalid = 1'b0;
        if (!hs) begin n_cmp++; n_fail++; $display("FAIL w_timeout: wready=0 required 1"); end
    endtask

    task automatic b_take(output logic [1:0] resp);
        int c; logic hs;
        c = 0; hs = 1'b0; resp = 2'bxx;
        bus.bready = 1'b1;
        while (!hs && c < 50) begin
            @(negedge clk); hs = bus.bvalid; resp = bus.bresp;
            @(posedge clk); #1; c++;
        end
        bus.bready = 1'b0;
        if (!hs) begin n_cmp++; n_fail++; $display("FAIL b_timeout: bvalid=0 required 1"); end
    endtask

    task automatic ar_send(input logic [AW-1:0] addr);
        int c; logic hs;
        c = 0; hs = 1'b0;
        bus.araddr = addr; bus.arvalid = 1'b1;
        while (!hs && c < 50) begin
            @(negedge clk); hs = bus.arready;
            @(posedge clk); #1; c++;
        end
        bus.arvalid = 1'b0;
        if (!hs) begin n_cmp++; n_fail++; $display("FAIL ar_timeout: arready=0 required 1"); end
    endtask

    task automatic r_take(output logic [DW-1:0] data, output logic [1:0] resp);
        int c; logic hs;
        c = 0; hs = 1'b0; data = 'x; resp = 2'bxx;
        bus.rready = 1'b1;
        while (!hs && c < 50) begin
            @(negedge clk); hs = bus.rvalid; data = bus.rdata; resp = bus.rresp;
            @(posedge clk); #1; c++;
        end
        bus.rready = 1'b0;
        if (!hs) begin n_cmp++; n_fail++; $display("FAIL r_timeout: rvalid=0 required 1"); end
    endtask

    task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        fork
            aw_send(addr);
            w_send(data, strb);
        join
        b_take(resp);
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                            output logic [1:0] resp);
        ar_send(addr);
        r_take(data, resp);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; #2;
        n_cmp++;
        if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b0) begin
            n_fail++; $display("FAIL reset_handshake: got %b required 00000",
                {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid});
        end
        n_cmp++;
        if ({bus.rdata, bus.bresp, bus.rresp} !== 36'h0) begin
            n_fail++; $display("FAIL reset_data_resp: got %h required 0", {bus.rdata, bus.bresp, bus.rresp});
        end
        n_cmp++;
        if ({operand_data, operand_wr_en, start_pulse} !== 67'h0) begin
            n_fail++; $display("FAIL reset_outputs: got %h required 0", {operand_data, operand_wr_en, start_pulse});
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
            n_fail++; $display("FAIL idle_ready: got %b required 111", {bus.awready, bus.wready, bus.arready});
        end
    endtask

    task automatic test_aw_then_w();
        int base; logic [1:0] resp;
        base = wr_pulse_cnt;
        aw_send(8'h08);
        @(negedge clk);
        n_cmp++;
        if ({bus.awready, bus.wready} !== 2'b01) begin
            n_fail++; $display("FAIL addr_ok_ready: got %b required 01", {bus.awready, bus.wready});
        end
        repeat (3) @(posedge clk);
        #1;
        w_send(32'h0000_0005, 4'hF);
        n_cmp++;
        if ({operand_wr_en, bus.bvalid} !== 3'b011) begin
            n_fail++; $display("FAIL aw_w_pulse: got wr_en/bvalid %b required 011", {operand_wr_en, bus.bvalid});
        end
        n_cmp++;
        if (operand_data[31:0] !== 32'h5) begin
            n_fail++; $display("FAIL aw_w_slot0: got %h required 00000005", operand_data[31:0]);
        end
        b_take(resp);
        n_cmp++;
        if ({resp, bus.bvalid} !== 3'b000) begin
            n_fail++; $display("FAIL aw_w_bresp: got resp/bvalid %b required 000", {resp, bus.bvalid});
        end
        n_cmp++;
        if (wr_pulse_cnt !== base + 1) begin
            n_fail++; $display("FAIL aw_w_pulse_count: got %0d required %0d", wr_pulse_cnt - base, 1);
        end
    endtask

    task automatic test_w_before_aw_strobe();
        logic [1:0] resp;
        axi_write(8'h0C, 32'h1122_3344, 4'hF, resp);
        n_cmp++;
        if ({resp, operand_data[63:32]} !== {2'b00, 32'h1122_3344}) begin
            n_fail++; $display("FAIL slot1_full: got %h required 11223344 resp 0", {resp, operand_data[63:32]});
        end
        w_send(32'hAABB_CCDD, 4'b0011);
        @(negedge clk);
        n_cmp++;
        if ({bus.awready, bus.wready} !== 2'b10) begin
            n_fail++; $display("FAIL data_ok_ready: got %b required 10", {bus.awready, bus.wready});
        end
        @(posedge clk); #1;
        aw_send(8'h0C);
        n_cmp++;
        if (operand_wr_en !== 2'b10) begin
            n_fail++; $display("FAIL strobe_wr_en: got %b required 10", operand_wr_en);
        end
        n_cmp++;
        if (operand_data !== {32'h1122_CCDD, 32'h0000_0005}) begin
            n_fail++; $display("FAIL strobe_merge: got %h required 1122ccdd00000005", operand_data);
        end
        b_take(resp);
        n_cmp++;
        if (resp !== 2'b00) begin n_fail++; $display("FAIL strobe_bresp: got %b required 00", resp); end
    endtask

    task automatic test_start();
        int base; logic [1:0] resp; logic [DW-1:0] d;
        base = start_cnt;
        axi_write(8'h00, 32'h1, 4'hF, resp);
        n_cmp++;
        if (start_cnt !== base + 1 || resp !== 2'b00) begin
            n_fail++; $display("FAIL start_pulse: got pulses %0d resp %b required 1 00", start_cnt - base, resp);
        end
        axi_write(8'h00, 32'h1, 4'hE, resp);
        n_cmp++;
        if (start_cnt !== base + 1) begin
            n_fail++; $display("FAIL start_no_strb0: got pulses %0d required 1", start_cnt - base);
        end
        axi_read(8'h00, d, resp);
        n_cmp++;
        if (d !== 32'h0 || resp !== ERR_RESP) begin
            n_fail++; $display("FAIL ctrl_read: got %h/%b required 00000000/%b", d, resp, ERR_RESP);
        end
    endtask

    task automatic test_results();
        logic [DW-1:0] d; logic [1:0] resp;
        result_data = {32'h0000_0010, 32'h0000_0020};
        result_valid = 1'b1;
        @(posedge clk); #1;
        result_valid = 1'b0;
        result_data = {32'hDEAD_BEEF, 32'hFEED_F00D};
        axi_read(8'h18, d, resp);
        n_cmp++;
        if (d !== 32'h20 || resp !== 2'b00) begin
            n_fail++; $display("FAIL result0: got %h/%b required 00000020/00", d, resp);
        end
        axi_read(8'h1C, d, resp);
        n_cmp++;
        if (d !== 32'h10 || resp !== 2'b00) begin
            n_fail++; $display("FAIL result1: got %h/%b required 00000010/00", d, resp);
        end
        axi_read(8'h04, d, resp);
        n_cmp++;
        if (d !== 32'h2) begin n_fail++; $display("FAIL status_done: got %h required 00000002", d); end
        axi_read(8'h04, d, resp);
        n_cmp++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL status_cleared: got %h required 00000000", d); end
    endtask

    task automatic test_sticky_set_wins();
        logic [DW-1:0] d; logic [1:0] resp;
        result_data = {32'h0000_0010, 32'h0000_0020};
        result_valid = 1'b1;
        @(posedge clk); #1;
        axi_read(8'h04, d, resp);
        result_valid = 1'b0;
        n_cmp++;
        if (d !== 32'h2) begin n_fail++; $display("FAIL set_wins_read: got %h required 00000002", d); end
        axi_read(8'h04, d, resp);
        n_cmp++;
        if (d !== 32'h2) begin n_fail++; $display("FAIL set_wins_kept: got %h required 00000002", d); end
        axi_read(8'h04, d, resp);
        n_cmp++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL set_wins_clear: got %h required 00000000", d); end
    endtask

    task automatic test_rready_stall();
        logic [DW-1:0] d; logic [1:0] resp;
        ar_send(8'h18);
        bus.araddr = 8'h1C; bus.arvalid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.rvalid, bus.arready, bus.rdata} !== {1'b1, 1'b0, 32'h20}) begin
                n_fail++; $display("FAIL stall_cycle%0d: got rvalid/arready/rdata %b/%b/%h required 1/0/00000020",
                    k, bus.rvalid, bus.arready, bus.rdata);
            end
        end
        @(posedge clk); #1;
        r_take(d, resp);
        n_cmp++;
        if (d !== 32'h20) begin n_fail++; $display("FAIL stall_data: got %h required 00000020", d); end
        ar_send(8'h1C);
        r_take(d, resp);
        n_cmp++;
        if (d !== 32'h10) begin n_fail++; $display("FAIL stall_next_read: got %h required 00000010", d); end
    endtask

    task automatic test_unmapped();
        int base; logic [1:0] resp; logic [DW-1:0] d;
        base = wr_pulse_cnt;
        axi_write(8'h40, 32'hFFFF_FFFF, 4'hF, resp);
        n_cmp++;
        if (resp !== ERR_RESP) begin n_fail++; $display("FAIL unmapped_bresp: got %b required %b", resp, ERR_RESP); end
        axi_write(8'h18, 32'hFFFF_FFFF, 4'hF, resp);
        n_cmp++;
        if (resp !== ERR_RESP) begin n_fail++; $display("FAIL result_wr_bresp: got %b required %b", resp, ERR_RESP); end
        n_cmp++;
        if (operand_data !== {32'h1122_CCDD, 32'h0000_0005} || wr_pulse_cnt !== base) begin
            n_fail++; $display("FAIL illegal_wr_no_change: got %h pulses %0d required 1122ccdd00000005 0",
                operand_data, wr_pulse_cnt - base);
        end
        axi_read(8'h40, d, resp);
        n_cmp++;
        if (d !== 32'h0 || resp !== ERR_RESP) begin
            n_fail++; $display("FAIL unmapped_read: got %h/%b required 00000000/%b", d, resp, ERR_RESP);
        end
        axi_read(8'h08, d, resp);
        n_cmp++;
        if (d !== 32'h0 || resp !== ERR_RESP) begin
            n_fail++; $display("FAIL operand_read: got %h/%b required 00000000/%b", d, resp, ERR_RESP);
        end
    endtask

    task automatic test_reset_midwrite();
        int base; logic [1:0] resp; logic [DW-1:0] d;
        base = wr_pulse_cnt;
        aw_send(8'h08);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b0) begin
            n_fail++; $display("FAIL midwrite_handshake: got %b required 00000",
                {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid});
        end
        n_cmp++;
        if ({operand_data, operand_wr_en, start_pulse} !== 67'h0) begin
            n_fail++; $display("FAIL midwrite_outputs: got %h required 0", {operand_data, operand_wr_en, start_pulse});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (wr_pulse_cnt !== base) begin
            n_fail++; $display("FAIL midwrite_no_pulse: got %0d pulses required 0", wr_pulse_cnt - base);
        end
        axi_write(8'h08, 32'h0000_0077, 4'hF, resp);
        n_cmp++;
        if (resp !== 2'b00 || operand_data !== {32'h0, 32'h77} || wr_pulse_cnt !== base + 1) begin
            n_fail++; $display("FAIL post_reset_write: got %h resp %b pulses %0d required 0000000000000077 00 1",
                operand_data, resp, wr_pulse_cnt - base);
        end
        axi_read(8'h18, d, resp);
        n_cmp++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL post_reset_result: got %h required 00000000", d); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] wresp, rresp; logic [DW-1:0] d;
        core_busy = 1'b1;
        fork
            axi_write(8'h0A, 32'hCAFE_0001, 4'hF, wresp);
            axi_read(8'h04, d, rresp);
        join
        core_busy = 1'b0;
        n_cmp++;
        if (wresp !== 2'b00 || operand_data[31:0] !== 32'hCAFE_0001) begin
            n_fail++; $display("FAIL concurrent_write: got %h/%b required cafe0001/00", operand_data[31:0], wresp);
        end
        n_cmp++;
        if (d !== 32'h1 || rresp !== 2'b00) begin
            n_fail++; $display("FAIL concurrent_status: got %h/%b required 00000001/00", d, rresp);
        end
        axi_write(8'h0C, 32'h0000_00AB, 4'h1, wresp);
        axi_write(8'h08, 32'h1234_5678, 4'hC, wresp);
        n_cmp++;
        if (operand_data !== {32'h0000_00AB, 32'h1234_0001}) begin
            n_fail++; $display("FAIL b2b_writes: got %h required 000000ab12340001", operand_data);
        end
    endtask

    initial begin
        bus.awaddr = '0; bus.awprot = 3'b0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arprot = 3'b0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        result_data = '0; result_valid = 1'b0; core_busy = 1'b0;
        test_reset();
        test_aw_then_w();
        test_w_before_aw_strobe();
        test_start();
        test_results();
        test_sticky_set_wins();
        test_rready_stall();
        test_unmapped();
        test_reset_midwrite();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
